pos_cache_motion_update_ctrl: RTL and testbench
===============================================

Name: pos_cache_motion_update_ctrl

Overview:
Sequences one motion-update pass over all position caches in the X×Y×Z cell grid.
- Reads each cell's particle count and positions from the active buffer and streams them into the motion update unit.
- Broadcasts the unit's results (new position plus destination cell) to all caches.
- Holds motion_update_enable high for the whole pass, so every cache fills its standby buffer and flips it when the pass ends.

Parameters:
DATA_WIDTH, 32, width of one coordinate.
ADDR_WIDTH, 8, cache address width; address 0 holds the particle count.
CELL_ID_WIDTH, 4, width of one cell coordinate.
X_DIM, 3, number of cells in x.
Y_DIM, 3, number of cells in y.
Z_DIM, 3, number of cells in z.
OUTST_WIDTH, 8, width of the outstanding-particle counter.
TIMEOUT, 1024, drain watchdog limit in cycles (used only with the optional feature).

Ports:
clk  in  1  clock.
rst  in  1  synchronous, active-high reset.
start  in  1  one-cycle pulse that begins a pass; ignored while busy.
busy  out  1  high from accepting start until done.
done  out  1  one-cycle pulse when the pass is complete.
rd_cell  out  3*CELL_ID_WIDTH  cell being read, {x,y,z}, 1-based.
rd_address  out  ADDR_WIDTH  cache read address.
rd_en  out  1  cache read enable.
rd_data  in  3*DATA_WIDTH  readout of the selected cache; valid 1 cycle after rd_en.
motion_update_enable  out  1  to all caches.
mu_in_data  out  3*DATA_WIDTH  position sent to the motion update unit.
mu_in_valid  out  1  valid for mu_in_data.
mu_out_data  in  3*DATA_WIDTH  updated position from the unit.
mu_out_dst_cell  in  3*CELL_ID_WIDTH  destination cell for mu_out_data.
mu_out_valid  in  1  valid for the unit's outputs.
bcast_data  out  3*DATA_WIDTH  broadcast in_data to caches.
bcast_dst_cell  out  3*CELL_ID_WIDTH  broadcast destination cell.
bcast_valid  out  1  broadcast valid.

Behaviour:
- Reset: all outputs 0, state IDLE, cell index (1,1,1), outstanding counter 0. Reset mid-pass aborts immediately to this state; no done pulse.
- States: IDLE, RD_NUM, WAIT_NUM, ISSUE, NEXT_CELL, DRAIN, GUARD0, GUARD1.
- IDLE: on start, go to RD_NUM; busy=1 and motion_update_enable=1 from the next cycle.
- RD_NUM: rd_en=1, rd_address=0; go to WAIT_NUM.
- WAIT_NUM: latch count = rd_data[ADDR_WIDTH-1:0].
  - count==0: go to NEXT_CELL.
  - otherwise: address=1, go to ISSUE.
- ISSUE: one read per cycle, rd_en=1, rd_address=1..count.
  - After issuing address==count, go to NEXT_CELL.
  - count=2^ADDR_WIDTH-1 must not wrap the address.
- Read data into the unit: mu_in_valid is rd_en delayed 1 cycle, asserted only for reads with address≥1; mu_in_data=rd_data.
- Cell iteration: z fastest, then y, then x. NEXT_CELL advances the index; after (X_DIM,Y_DIM,Z_DIM) go to DRAIN, otherwise to RD_NUM.
- Outstanding counter:
  - +1 on each mu_in_valid, −1 on each mu_out_valid; simultaneous events leave it unchanged.
  - Overflow is not checked; OUTST_WIDTH must cover the unit's pipeline depth.
- Broadcast path: bcast_* are mu_out_* registered once (1-cycle latency), in every state including IDLE.
- DRAIN: leave when outstanding==0 and mu_in_valid==0; then motion_update_enable=0 and go to GUARD0.
- GUARD0, GUARD1: give the caches time to write their count and flip buffers. After GUARD1, done=1 for one cycle, busy=0, go to IDLE.
- rd_en is never asserted in DRAIN or the GUARD states.
- start during busy: ignored.

Optional Feature:
MU_DRAIN_TIMEOUT_EN
- With the macro: adds output timeout_err (1 bit, sticky, cleared only by rst). If DRAIN lasts TIMEOUT cycles, force the exit to GUARD0, set timeout_err=1, and finish the pass normally with a done pulse.
- Without the macro: DRAIN waits indefinitely and the port is absent.

Test Plan:
1. 1×1×2 grid, counts 3 and 2, unit modelled as a 4-cycle delay → rd_address sequence 0,1,2,3,0,1,2; exactly 5 mu_in_valid and 5 bcast_valid; done pulse 3 cycles after the last bcast_valid; motion_update_enable low for both GUARD cycles.
2. Grid where cell (1,1,2) has count 0 → exactly one read at address 0 for that cell, then it is skipped; total mu_in_valid equals the sum of the other cells' counts.
3. Simultaneous mu_in_valid and mu_out_valid for 10 cycles → outstanding counter constant; DRAIN exits only after the final return.
4. rst asserted during ISSUE → next cycle all outputs 0, no done pulse; a new start runs a full, correct pass.
5. start pulses while busy → no restart; exactly one done pulse per accepted start.
6. (MU_DRAIN_TIMEOUT_EN, TIMEOUT=16) unit drops one particle → done occurs 16 cycles into DRAIN plus 2 GUARD cycles; timeout_err=1 and stays 1 until rst.

Source files
------------

// File: rtl/pos_cache_motion_update_ctrl.sv
// Motion-update pass sequencer: walks every cell, streams its particles into the
// motion update unit, rebroadcasts results. Optional drain watchdog: MU_DRAIN_TIMEOUT_EN.
module pos_cache_motion_update_ctrl #(
  parameter int DATA_WIDTH    = 32,
  parameter int ADDR_WIDTH    = 8,
  parameter int CELL_ID_WIDTH = 4,
  parameter int X_DIM         = 3,
  parameter int Y_DIM         = 3,
  parameter int Z_DIM         = 3,
  parameter int OUTST_WIDTH   = 8,
  parameter int TIMEOUT       = 1024
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  output logic                       busy,
  output logic                       done,
  output logic [3*CELL_ID_WIDTH-1:0] rd_cell,
  output logic [ADDR_WIDTH-1:0]      rd_address,
  output logic                       rd_en,
  input  logic [3*DATA_WIDTH-1:0]    rd_data,
  output logic                       motion_update_enable,
  output logic [3*DATA_WIDTH-1:0]    mu_in_data,
  output logic                       mu_in_valid,
  input  logic [3*DATA_WIDTH-1:0]    mu_out_data,
  input  logic [3*CELL_ID_WIDTH-1:0] mu_out_dst_cell,
  input  logic                       mu_out_valid,
  output logic [3*DATA_WIDTH-1:0]    bcast_data,
  output logic [3*CELL_ID_WIDTH-1:0] bcast_dst_cell,
  output logic                       bcast_valid
`ifdef MU_DRAIN_TIMEOUT_EN
  , output logic                     timeout_err
`endif
);

  typedef enum logic [2:0] {IDLE, RD_NUM, WAIT_NUM, ISSUE, NEXT_CELL, DRAIN, GUARD0, GUARD1} state_t;

  localparam logic [CELL_ID_WIDTH-1:0] C_ONE = CELL_ID_WIDTH'(1);
  localparam logic [CELL_ID_WIDTH-1:0] XM    = CELL_ID_WIDTH'(X_DIM);
  localparam logic [CELL_ID_WIDTH-1:0] YM    = CELL_ID_WIDTH'(Y_DIM);
  localparam logic [CELL_ID_WIDTH-1:0] ZM    = CELL_ID_WIDTH'(Z_DIM);
  localparam logic [ADDR_WIDTH-1:0]    A_ONE = ADDR_WIDTH'(1);
  localparam logic [OUTST_WIDTH-1:0]   O_ONE = OUTST_WIDTH'(1);

  state_t                   state;
  logic [CELL_ID_WIDTH-1:0] cx, cy, cz, nx, ny, nz;
  logic                     last;
  logic [ADDR_WIDTH-1:0]    count;
  logic [OUTST_WIDTH-1:0]   outst;
`ifdef MU_DRAIN_TIMEOUT_EN
  localparam int TCW = $clog2(TIMEOUT + 1);
  logic [TCW-1:0] tcnt;
`endif

  // Data returns one cycle after the read, exactly when mu_in_valid is up.
  assign mu_in_data = mu_in_valid ? rd_data : '0;

  // z fastest, then y, then x; last flags the final cell of the grid.
  always_comb begin
    nx = cx; ny = cy; nz = cz; last = 1'b0;
    if (cz != ZM) nz = cz + C_ONE;
    else begin
      nz = C_ONE;
      if (cy != YM) ny = cy + C_ONE;
      else begin
        ny = C_ONE;
        if (cx != XM) nx = cx + C_ONE;
        else begin
          nx = C_ONE;
          last = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      busy <= 1'b0; done <= 1'b0; rd_en <= 1'b0; rd_address <= '0; rd_cell <= '0;
      motion_update_enable <= 1'b0; mu_in_valid <= 1'b0;
      bcast_data <= '0; bcast_dst_cell <= '0; bcast_valid <= 1'b0;
      cx <= C_ONE; cy <= C_ONE; cz <= C_ONE; count <= '0; outst <= '0;
`ifdef MU_DRAIN_TIMEOUT_EN
      tcnt <= '0; timeout_err <= 1'b0;
`endif
    end else begin
      done           <= 1'b0;
      mu_in_valid    <= rd_en && (rd_address != '0);
      bcast_data     <= mu_out_data;
      bcast_dst_cell <= mu_out_dst_cell;
      bcast_valid    <= mu_out_valid;
      case ({mu_in_valid, mu_out_valid})
        2'b10:   outst <= outst + O_ONE;
        2'b01:   outst <= outst - O_ONE;
        default: ;
      endcase
      case (state)
        IDLE: if (start) begin
          busy <= 1'b1; motion_update_enable <= 1'b1;
          rd_en <= 1'b1; rd_address <= '0; rd_cell <= {cx, cy, cz};
          state <= RD_NUM;
        end
        RD_NUM: begin
          rd_en <= 1'b0;
          state <= WAIT_NUM;
        end
        WAIT_NUM: begin
          count <= rd_data[ADDR_WIDTH-1:0];
          if (rd_data[ADDR_WIDTH-1:0] == '0) state <= NEXT_CELL;
          else begin
            rd_en <= 1'b1; rd_address <= A_ONE;
            state <= ISSUE;
          end
        end
        // Compare before incrementing so a full cache never wraps the address.
        ISSUE: if (rd_address == count) begin
          rd_en <= 1'b0;
          state <= NEXT_CELL;
        end else rd_address <= rd_address + A_ONE;
        NEXT_CELL: begin
          cx <= nx; cy <= ny; cz <= nz;
          if (last) begin
            state <= DRAIN;
`ifdef MU_DRAIN_TIMEOUT_EN
            tcnt <= '0;
`endif
          end else begin
            rd_en <= 1'b1; rd_address <= '0; rd_cell <= {nx, ny, nz};
            state <= RD_NUM;
          end
        end
        DRAIN: if (outst == '0 && !mu_in_valid) begin
          motion_update_enable <= 1'b0;
          state <= GUARD0;
        end
`ifdef MU_DRAIN_TIMEOUT_EN
        else if (tcnt == TCW'(TIMEOUT - 1)) begin
          motion_update_enable <= 1'b0; timeout_err <= 1'b1;
          state <= GUARD0;
        end else tcnt <= tcnt + TCW'(1);
`endif
        GUARD0: state <= GUARD1;
        GUARD1: begin
          done <= 1'b1; busy <= 1'b0; rd_cell <= '0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pos_cache_motion_update_ctrl.sv
// Directed bench: 1x1x2 grid, cache model with 1-cycle read latency, unit as 4-cycle delay.
module tb_pos_cache_motion_update_ctrl;
  localparam int DW = 32, AW = 8, CW = 4, TO = 16;

  logic clk = 1'b0, rst = 1'b1, start = 1'b0;
  logic busy, done, rd_en, mue, mu_in_valid, mu_out_valid, bcast_valid;
  logic [3*CW-1:0] rd_cell, mu_out_dst_cell, bcast_dst_cell;
  logic [AW-1:0]   rd_address;
  logic [3*DW-1:0] rd_data, mu_in_data, mu_out_data, bcast_data;
`ifdef MU_DRAIN_TIMEOUT_EN
  logic timeout_err;
`endif

  always #5 clk = ~clk;

  pos_cache_motion_update_ctrl #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .CELL_ID_WIDTH(CW),
    .X_DIM(1), .Y_DIM(1), .Z_DIM(2), .OUTST_WIDTH(8), .TIMEOUT(TO)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
    .rd_cell(rd_cell), .rd_address(rd_address), .rd_en(rd_en), .rd_data(rd_data),
    .motion_update_enable(mue), .mu_in_data(mu_in_data), .mu_in_valid(mu_in_valid),
    .mu_out_data(mu_out_data), .mu_out_dst_cell(mu_out_dst_cell), .mu_out_valid(mu_out_valid),
    .bcast_data(bcast_data), .bcast_dst_cell(bcast_dst_cell), .bcast_valid(bcast_valid)
`ifdef MU_DRAIN_TIMEOUT_EN
    , .timeout_err(timeout_err)
`endif
  );

  // Cache model: address 0 holds the count, others a tagged position.
  int cnt0 = 0, cnt1 = 0;
  function automatic logic [3*DW-1:0] mem_val(input logic [3*CW-1:0] c, input logic [AW-1:0] a);
    int n;
    n = (c[CW-1:0] == 4'd2) ? cnt1 : cnt0;
    if (a == '0) return 96'(n);
    return {32'(c), 32'(a), 32'hA500_0000 | 32'(a)};
  endfunction
  always @(posedge clk) rd_data <= rd_en ? mem_val(rd_cell, rd_address) : '0;

  // Motion update unit: fixed 4-cycle delay, optionally loses one particle.
  logic [3:0]      pv;
  logic [3*DW-1:0] pd [4];
  int n_pv = 0, drop_idx = -1;
  always @(posedge clk) begin
    if (rst) pv <= '0;
    else begin
      pv <= {pv[2:0], mu_in_valid};
      pd[0] <= mu_in_data;
      for (int i = 1; i < 4; i++) pd[i] <= pd[i-1];
      if (pv[3]) n_pv <= n_pv + 1;
    end
  end
  assign mu_out_valid    = pv[3] && (n_pv != drop_idx);
  assign mu_out_data     = mu_out_valid ? pd[3] + 96'd1 : '0;
  assign mu_out_dst_cell = mu_out_valid ? (pd[3][3*CW-1:0] ^ 12'h5a5) : '0;

  // Monitor: cumulative event counters and running mismatch tallies.
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;
  int n_rd = 0, n_a0 = 0, n_in = 0, n_bc = 0, n_done = 0, n_ob = 0, n_bb = 0, n_ib = 0;
  int last_bc = 0, last_rd = 0, done_cyc = 0, mdl = 0;
  int addr_log[$];
  logic mue_h [0:16383];
  logic [3*DW+3*CW:0] prev;
  always @(negedge clk) begin
    mue_h[cyc % 16384] = mue;
    if (rst) begin
      mdl = 0; prev = '0;
    end else begin
      if (dut.outst != 8'(mdl)) n_ob++;
      mdl += int'(mu_in_valid) - int'(mu_out_valid);
      if ({bcast_valid, bcast_data, bcast_dst_cell} != prev) n_bb++;
      prev = {mu_out_valid, mu_out_data, mu_out_dst_cell};
      if (mu_in_valid && mu_in_data != rd_data) n_ib++;
      if (rd_en) begin
        addr_log.push_back(int'(rd_address)); n_rd++; last_rd = cyc;
        if (rd_address == '0) n_a0++;
      end
      if (mu_in_valid) n_in++;
      if (bcast_valid) begin n_bc++; last_bc = cyc; end
      if (done) begin n_done++; done_cyc = cyc; end
    end
  end

  int errs = 0, checks = 0;
  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  typedef struct {
    int c0; int c1; bit extra;
    int exp_rd; int exp_in; int exp_max;
  } vec_t;
  vec_t vt [6];

  int s_rd, s_in, s_bc, s_a0, s_done, s_bad, s_log;

  task automatic run_pass(input int c0, input int c1, input bit extra);
    bit got;
    cnt0 = c0; cnt1 = c1;
    s_rd = n_rd; s_in = n_in; s_bc = n_bc; s_a0 = n_a0; s_done = n_done;
    s_bad = n_ob + n_bb + n_ib; s_log = addr_log.size();
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    chk("busy_mue_after_start", {busy, mue}, 2'b11);
    got = 1'b0;
    for (int k = 0; k < 3000 && !got; k++) begin
      @(negedge clk);
      start = extra && (k == 3 || k == 10);
      if (done) got = 1'b1;
    end
    start = 1'b0;
    chk("done_seen", got, 1);
    repeat (8) @(negedge clk);
    chk("idle_after_done", busy, 0);
  endtask

  task automatic check_row(input vec_t v);
    int mx;
    mx = 0;
    for (int i = s_log; i < addr_log.size(); i++) if (addr_log[i] > mx) mx = addr_log[i];
    chk("reads", n_rd - s_rd, v.exp_rd);
    chk("addr0_reads", n_a0 - s_a0, 2);
    chk("mu_in_valids", n_in - s_in, v.exp_in);
    chk("bcast_valids", n_bc - s_bc, v.exp_in);
    chk("max_addr", mx, v.exp_max);
    chk("done_pulses", n_done - s_done, 1);
    chk("stream_integrity", n_ob + n_bb + n_ib - s_bad, 0);
    if (v.exp_in > 0) chk("done_after_last_bcast", done_cyc - last_bc, 3);
  endtask

  initial begin
    int exp_seq [7];
    int mism;
    vt[0] = '{3,   2, 1'b0, 7,   5,   3};
    vt[1] = '{3,   0, 1'b0, 5,   3,   3};
    vt[2] = '{0,   0, 1'b0, 2,   0,   0};
    vt[3] = '{14,  0, 1'b0, 16,  14,  14};
    vt[4] = '{1,   1, 1'b1, 4,   2,   1};
    vt[5] = '{255, 1, 1'b0, 258, 256, 255};
    exp_seq = '{0, 1, 2, 3, 0, 1, 2};

    repeat (3) @(negedge clk);
    chk("reset_outputs_zero", $countones({busy, done, rd_en, mue, mu_in_valid, bcast_valid,
        rd_cell, rd_address, mu_in_data, bcast_data, bcast_dst_cell}), 0);
`ifdef MU_DRAIN_TIMEOUT_EN
    chk("reset_timeout_err", timeout_err, 0);
`endif
    rst = 1'b0;
    repeat (2) @(negedge clk);

    for (int r = 0; r < 6; r++) begin
      run_pass(vt[r].c0, vt[r].c1, vt[r].extra);
      check_row(vt[r]);
      if (r == 0) begin
        mism = 0;
        for (int i = 0; i < 7; i++) if (addr_log[s_log + i] != exp_seq[i]) mism++;
        chk("addr_sequence", mism, 0);
        chk("mue_guard_cycles", {mue_h[(done_cyc-3) % 16384], mue_h[(done_cyc-2) % 16384],
            mue_h[(done_cyc-1) % 16384]}, 3'b100);
      end
    end

    // Reset in the middle of ISSUE aborts without a done pulse.
    cnt0 = 14; cnt1 = 0;
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    mism = 1;
    for (int k = 0; k < 50 && mism != 0; k++) begin
      @(negedge clk);
      if (rd_en && rd_address == 8'd3) mism = 0;
    end
    chk("reached_issue", mism, 0);
    rst = 1'b1;
    @(negedge clk);
    chk("midpass_reset_outputs_zero", $countones({busy, done, rd_en, mue, mu_in_valid, bcast_valid,
        rd_cell, rd_address, mu_in_data, bcast_data, bcast_dst_cell}), 0);
    rst = 1'b0;
    s_done = n_done;
    repeat (30) @(negedge clk);
    chk("no_done_after_abort", n_done - s_done, 0);
    run_pass(vt[0].c0, vt[0].c1, 1'b0);
    check_row(vt[0]);

`ifdef MU_DRAIN_TIMEOUT_EN
    // Lost particle: DRAIN gives up after TIMEOUT cycles, pass still completes.
    drop_idx = n_pv;
    run_pass(3, 2, 1'b0);
    chk("to_mu_in_valids", n_in - s_in, 5);
    chk("to_bcast_valids", n_bc - s_bc, 4);
    chk("to_done_timing", done_cyc - last_rd, TO + 4);
    chk("to_err_set", timeout_err, 1);
    repeat (10) @(negedge clk);
    chk("to_err_sticky", timeout_err, 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("to_err_cleared", timeout_err, 0);
`endif

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
